// File: rtl/cpu_branch_ctrl_pkg.sv
// Shared encodings for the EX-side next-PC controller: opcodes, pc_inc codes and FSM states.
package cpu_branch_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_SYSCALL = 6'b001100;

    localparam logic [1:0] PC_INC_HOLD = 2'b00;
    localparam logic [1:0] PC_INC_STEP = 2'b01;
    localparam logic [1:0] PC_INC_LOAD = 2'b10;

    typedef enum logic [1:0] {
        StRun,
        StFlush,
        StHalt
    } state_e;

endpackage

// File: rtl/cpu_branch_target.sv
// Combinational decode of one instruction: branch condition, redirect target, syscall and jal flags.
module cpu_branch_target
    import cpu_branch_ctrl_pkg::*;
(
    input  logic [31:0] ins,
    input  logic [31:0] pc,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        taken,
    output logic [31:0] target,
    output logic        is_syscall,
    output logic        is_jal
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] pc4;
    logic [31:0] br_target;
    logic [31:0] jmp_target;

    assign opcode     = ins[31:26];
    assign funct      = ins[5:0];
    assign pc4        = pc + 32'd4;
    assign br_target  = pc4 + {{14{ins[15]}}, ins[15:0], 2'b00};
    assign jmp_target = {pc4[31:28], ins[25:0], 2'b00};

    always_comb begin
        taken      = 1'b0;
        target     = 32'd0;
        is_syscall = 1'b0;
        is_jal     = 1'b0;
        unique case (opcode)
            OP_BEQ: begin
                taken  = (rs_data == rt_data);
                target = br_target;
            end
            OP_BNE: begin
                taken  = (rs_data != rt_data);
                target = br_target;
            end
            OP_J: begin
                taken  = 1'b1;
                target = jmp_target;
            end
            OP_JAL: begin
                taken  = 1'b1;
                target = jmp_target;
                is_jal = 1'b1;
            end
            OP_RTYPE: begin
                if (funct == FN_JR) begin
                    taken  = 1'b1;
                    target = rs_data;
                end
                is_syscall = (funct == FN_SYSCALL);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_branch_ctrl.sv
// EX-side next-PC controller: resolves control transfers, squashes wrong-path fetches,
// handles stall and syscall halt, and counts taken redirects.
module cpu_branch_ctrl
    import cpu_branch_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_SLOTS = 1,
    parameter int unsigned DELAY_SLOT  = 0
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] current_pc,
    input  logic [31:0] ins,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        stall,
    output logic [1:0]  pc_inc,
    output logic [31:0] next_pc,
    output logic        kill,
    output logic        link_we,
    output logic [31:0] link_data,
    output logic        halted,
    output logic [31:0] branch_count
);

    localparam int unsigned CntW = (FLUSH_SLOTS < 2) ? 1 : $clog2(FLUSH_SLOTS + 1);
    localparam logic [CntW-1:0] FlushInit = CntW'(FLUSH_SLOTS);
    localparam logic [31:0] LinkOffset = (DELAY_SLOT != 0) ? 32'd8 : 32'd4;

    state_e          state_q, state_d;
    logic [CntW-1:0] flush_q, flush_d;
    logic            halted_q, halted_d;
    logic [31:0]     count_q, count_d;

    logic        dec_taken;
    logic [31:0] dec_target;
    logic        dec_syscall;
    logic        dec_jal;
    logic        first_slot;

    cpu_branch_target u_target (
        .ins        (ins),
        .pc         (current_pc),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .taken      (dec_taken),
        .target     (dec_target),
        .is_syscall (dec_syscall),
        .is_jal     (dec_jal)
    );

    assign first_slot   = (flush_q == FlushInit);
    assign link_data    = current_pc + LinkOffset;
    assign halted       = halted_q;
    assign branch_count = count_q;

    always_comb begin
        pc_inc   = PC_INC_STEP;
        next_pc  = 32'd0;
        kill     = 1'b0;
        link_we  = 1'b0;
        state_d  = state_q;
        flush_d  = flush_q;
        halted_d = halted_q;
        count_d  = count_q;

        if (clr) begin
            kill = 1'b1;
        end else begin
            unique case (state_q)
                StHalt: begin
                    pc_inc = PC_INC_HOLD;
                    kill   = 1'b1;
                end
                StFlush: begin
                    // A delay-slot instruction may still link but never redirects.
                    if ((DELAY_SLOT != 0) && first_slot) begin
                        link_we = dec_jal;
                    end else begin
                        kill = 1'b1;
                    end
                    flush_d = flush_q - CntW'(1);
                    if (flush_q == CntW'(1)) begin
                        state_d = StRun;
                    end
                end
                default: begin
                    if (stall) begin
                        pc_inc = PC_INC_HOLD;
                    end else if (dec_syscall) begin
                        pc_inc   = PC_INC_HOLD;
                        halted_d = 1'b1;
                        state_d  = StHalt;
                    end else if (dec_taken) begin
                        pc_inc  = PC_INC_LOAD;
                        next_pc = dec_target;
                        link_we = dec_jal;
                        count_d = count_q + 32'd1;
                        if (FLUSH_SLOTS != 0) begin
                            state_d = StFlush;
                            flush_d = FlushInit;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= StRun;
            flush_q  <= '0;
            halted_q <= 1'b0;
            count_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            flush_q  <= flush_d;
            halted_q <= halted_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_cpu_branch_ctrl.sv
// Directed bench for cpu_branch_ctrl (FLUSH_SLOTS=1, DELAY_SLOT=0): cycle table plus halt/clr sequences.
module tb_cpu_branch_ctrl;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] current_pc;
    logic [31:0] ins;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        stall;
    logic [1:0]  pc_inc;
    logic [31:0] next_pc;
    logic        kill;
    logic        link_we;
    logic [31:0] link_data;
    logic        halted;
    logic [31:0] branch_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cpu_branch_ctrl #(
        .FLUSH_SLOTS (1),
        .DELAY_SLOT  (0)
    ) dut (
        .clk          (clk),
        .clr          (clr),
        .current_pc   (current_pc),
        .ins          (ins),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .stall        (stall),
        .pc_inc       (pc_inc),
        .next_pc      (next_pc),
        .kill         (kill),
        .link_we      (link_we),
        .link_data    (link_data),
        .halted       (halted),
        .branch_count (branch_count)
    );

    typedef struct {
        logic        clr;
        logic        stall;
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [1:0]  e_pc_inc;
        logic [31:0] e_next_pc;
        logic        e_kill;
        logic        e_link_we;
        logic [31:0] e_link_data;
        logic        e_halted;
        logic [31:0] e_count;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] NOP     = 32'h0000_0000;
    localparam logic [31:0] SYSCALL = 32'h0000_000C;
    localparam logic [31:0] JR31    = 32'h03E0_0008;

    function automatic vec_t mk(logic c, logic s, logic [31:0] p, logic [31:0] i,
                                logic [31:0] a, logic [31:0] b, logic [1:0] epi,
                                logic [31:0] enp, logic ek, logic elw, logic [31:0] eld,
                                logic eh, logic [31:0] ec);
        vec_t v;
        v.clr = c; v.stall = s; v.pc = p; v.ins = i; v.rs = a; v.rt = b;
        v.e_pc_inc = epi; v.e_next_pc = enp; v.e_kill = ek; v.e_link_we = elw;
        v.e_link_data = eld; v.e_halted = eh; v.e_count = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic c, input logic s, input logic [31:0] p,
                         input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        clr = c; stall = s; current_pc = p; ins = i; rs_data = a; rt_data = b;
    endtask

    // Inputs are driven just after a rising edge; outputs are checked mid-cycle.
    task automatic check_all(input string tag, input logic [1:0] epi, input logic [31:0] enp,
                             input logic ek, input logic elw, input logic [31:0] eld,
                             input logic eh, input logic [31:0] ec);
        #4;
        chk({tag, ".pc_inc"}, {30'd0, pc_inc}, {30'd0, epi});
        chk({tag, ".next_pc"}, next_pc, enp);
        chk({tag, ".kill"}, {31'd0, kill}, {31'd0, ek});
        chk({tag, ".link_we"}, {31'd0, link_we}, {31'd0, elw});
        chk({tag, ".link_data"}, link_data, eld);
        chk({tag, ".halted"}, {31'd0, halted}, {31'd0, eh});
        chk({tag, ".count"}, branch_count, ec);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // clr, stall, pc, ins, rs, rt | pc_inc, next_pc, kill, link_we, link_data, halted, count
        vecs.push_back(mk(1, 0, 32'h0, NOP, 0, 0, 2'b01, 32'h0, 1, 0, 32'h4, 0, 0));
        vecs.push_back(mk(1, 0, 32'h0, NOP, 0, 0, 2'b01, 32'h0, 1, 0, 32'h4, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0, NOP, 0, 0, 2'b01, 32'h0, 0, 0, 32'h4, 0, 0));
        // beq taken, imm=3 -> 0x20, then one killed slot
        vecs.push_back(mk(0, 0, 32'h10, 32'h1022_0003, 5, 5, 2'b10, 32'h20, 0, 0, 32'h14, 0, 0));
        vecs.push_back(mk(0, 0, 32'h14, NOP, 0, 0, 2'b01, 32'h0, 1, 0, 32'h18, 0, 1));
        // bne with equal operands not taken; backward beq to itself
        vecs.push_back(mk(0, 0, 32'h20, 32'h1422_0003, 7, 7, 2'b01, 32'h0, 0, 0, 32'h24, 0, 1));
        vecs.push_back(mk(0, 0, 32'h40, 32'h1022_FFFF, 9, 9, 2'b10, 32'h40, 0, 0, 32'h44, 0, 1));
        vecs.push_back(mk(0, 0, 32'h44, NOP, 0, 0, 2'b01, 32'h0, 1, 0, 32'h48, 0, 2));
        // jal links; killed jr must not redirect
        vecs.push_back(mk(0, 0, 32'h100, 32'h0C00_0100, 0, 0, 2'b10, 32'h400, 0, 1, 32'h104, 0, 2));
        vecs.push_back(mk(0, 0, 32'h104, JR31, 32'h999, 0, 2'b01, 32'h0, 1, 0, 32'h108, 0, 3));
        // bne taken; killed syscall with stall asserted in flush
        vecs.push_back(mk(0, 0, 32'h400, 32'h1422_0010, 1, 2, 2'b10, 32'h444, 0, 0, 32'h404, 0, 3));
        vecs.push_back(mk(0, 1, 32'h404, SYSCALL, 0, 0, 2'b01, 32'h0, 1, 0, 32'h408, 0, 4));
        // j held by stall for 3 cycles, then redirects once
        vecs.push_back(mk(0, 1, 32'h444, 32'h0800_0800, 0, 0, 2'b00, 32'h0, 0, 0, 32'h448, 0, 4));
        vecs.push_back(mk(0, 1, 32'h444, 32'h0800_0800, 0, 0, 2'b00, 32'h0, 0, 0, 32'h448, 0, 4));
        vecs.push_back(mk(0, 1, 32'h444, 32'h0800_0800, 0, 0, 2'b00, 32'h0, 0, 0, 32'h448, 0, 4));
        vecs.push_back(mk(0, 0, 32'h444, 32'h0800_0800, 0, 0, 2'b10, 32'h2000, 0, 0, 32'h448, 0, 4));
        vecs.push_back(mk(0, 0, 32'h448, NOP, 0, 0, 2'b01, 32'h0, 1, 0, 32'h44C, 0, 5));
        // jr via rs
        vecs.push_back(mk(0, 0, 32'h2000, JR31, 32'h3000, 0, 2'b10, 32'h3000, 0, 0, 32'h2004, 0, 5));
        vecs.push_back(mk(0, 0, 32'h2004, NOP, 0, 0, 2'b01, 32'h0, 1, 0, 32'h2008, 0, 6));
        vecs.push_back(mk(0, 0, 32'h3000, 32'h1022_0003, 1, 2, 2'b01, 32'h0, 0, 0, 32'h3004, 0, 6));
        // j keeps pc4[31:28]; beq at top of memory wraps to 0
        vecs.push_back(mk(0, 0, 32'hF000_0000, 32'h0800_0004, 0, 0, 2'b10, 32'hF000_0010, 0, 0,
                          32'hF000_0004, 0, 6));
        vecs.push_back(mk(0, 0, 32'hF000_0004, NOP, 0, 0, 2'b01, 32'h0, 1, 0, 32'hF000_0008, 0, 7));
        vecs.push_back(mk(0, 0, 32'hFFFF_FFFC, 32'h1022_0000, 3, 3, 2'b10, 32'h0, 0, 0, 32'h0, 0, 7));
        vecs.push_back(mk(0, 0, 32'h0, NOP, 0, 0, 2'b01, 32'h0, 1, 0, 32'h4, 0, 8));

        drive(1, 0, 0, NOP, 0, 0);
        @(posedge clk);
        #1;
        foreach (vecs[k]) begin
            drive(vecs[k].clr, vecs[k].stall, vecs[k].pc, vecs[k].ins, vecs[k].rs, vecs[k].rt);
            check_all($sformatf("v%0d", k), vecs[k].e_pc_inc, vecs[k].e_next_pc, vecs[k].e_kill,
                      vecs[k].e_link_we, vecs[k].e_link_data, vecs[k].e_halted, vecs[k].e_count);
        end

        // syscall retires, then HALT holds regardless of presented instruction
        drive(0, 0, 32'h10, SYSCALL, 0, 0);
        check_all("sys", 2'b00, 32'h0, 0, 0, 32'h14, 0, 8);
        for (int i = 0; i < 10; i++) begin
            drive(0, i[0], 32'h10 + 32'(i), (i[1] ? 32'h0C00_0040 : 32'h0800_0040), 0, 0);
            check_all($sformatf("halt%0d", i), 2'b00, 32'h0, 1, 0, 32'h14 + 32'(i), 1, 8);
        end
        drive(1, 0, 32'h20, 32'h0800_0040, 0, 0);
        check_all("clr_halt", 2'b01, 32'h0, 1, 0, 32'h24, 1, 8);
        drive(0, 0, 32'h20, NOP, 0, 0);
        check_all("post_halt", 2'b01, 32'h0, 0, 0, 32'h24, 0, 0);

        // clr in the middle of a flush drops the squash
        drive(0, 0, 32'h30, 32'h1022_0001, 4, 4);
        check_all("pre_flush", 2'b10, 32'h38, 0, 0, 32'h34, 0, 0);
        drive(1, 0, 32'h34, NOP, 0, 0);
        check_all("clr_flush", 2'b01, 32'h0, 1, 0, 32'h38, 0, 1);
        drive(0, 0, 32'h0, NOP, 0, 0);
        check_all("post_flush", 2'b01, 32'h0, 0, 0, 32'h4, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
